note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 72 +++++++
 rtl/note_sequencer.sv | 144 ++++++++++++++
 tb/tb_note_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants, command layout and sequencer state encoding for the note sequencer.
package note_pkg;

  localparam int NOTE_W = 5;
  localparam int DUR_W  = 8;
  localparam int CMD_W  = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd31;
  localparam logic [NOTE_W-1:0] NUM_NOTES = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } cmd_t;

  // Indices 24..31 have no table entry and play as silent rests.
  function automatic logic is_sounding(input logic [NOTE_W-1:0] n);
    return n < NUM_NOTES;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through read, so the head entry
// is visible in the same cycle it is popped.
module cmd_fifo
  import note_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  cmd_t                   wr_data_i,
  input  logic                   pop_i,
  output cmd_t                   rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            push_ok, pop_ok;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued {note, duration} commands: each note sounds for dur ticks, then
// a fixed silent gap, with pause/flush control over the running sequence.
module note_sequencer
  import note_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int GAP_TICKS = 1,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NOTE_W-1:0]      cmd_note,
  input  logic [DUR_W-1:0]       cmd_dur,
  input  logic                   pause,
  input  logic                   flush,
  output logic [NOTE_W-1:0]      note,
  output logic                   gate,
  output logic                   note_start,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST   = DUR_W'(GAP_TICKS - 1);
  localparam bit                HAS_GAP    = (GAP_TICKS > 0);

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [DUR_W-1:0]    tick_q, tick_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                start_q, start_d;

  cmd_t                fifo_wr, fifo_rd;
  logic                fifo_full, fifo_empty, push, work_pending;
  logic [DUR_W-1:0]    last_tick;

  assign cmd_ready    = !fifo_full && !flush;
  assign push         = cmd_valid && cmd_ready;
  assign fifo_wr      = '{note: cmd_note, dur: cmd_dur};
  assign work_pending = !fifo_empty || push;
  assign last_tick    = (state_q == ST_PLAY) ? dur_q - 1'b1 : GAP_LAST;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (flush),
    .push_i    (push),
    .wr_data_i (fifo_wr),
    .pop_i     (state_q == ST_LOAD),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    note_d  = note_q;
    start_d = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      note_d  = NOTE_REST;
      presc_d = '0;
      tick_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          note_d = NOTE_REST;
          if (work_pending) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (fifo_rd.dur != '0) begin
            state_d = ST_PLAY;
            note_d  = fifo_rd.note;
            dur_d   = fifo_rd.dur;
            presc_d = '0;
            tick_d  = '0;
            start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            note_d  = NOTE_REST;
          end
        end
        ST_PLAY, ST_GAP: begin
          if (!pause) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              tick_d  = tick_q + 1'b1;
              if (tick_q == last_tick) begin
                tick_d = '0;
                // Gap follows the note unless disabled; otherwise chain straight on.
                if (state_q == ST_PLAY && HAS_GAP) begin
                  state_d = ST_GAP;
                end else if (work_pending) begin
                  state_d = ST_LOAD;
                end else begin
                  state_d = ST_IDLE;
                  note_d  = NOTE_REST;
                end
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          note_d  = NOTE_REST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      note_q  <= NOTE_REST;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      start_q <= start_d;
    end
  end

  assign note       = note_q;
  assign gate       = (state_q == ST_PLAY) && is_sounding(note_q) && !pause;
  assign note_start = start_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized
// traffic, all checked every cycle against a remaining-cycles reference model.
module tb_note_sequencer;

  localparam int TD    = 4;
  localparam int GAPT  = 1;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_GAP  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [4:0]    cmd_note = '0;
  logic [7:0]    cmd_dur = '0;
  logic          pause = 1'b0;
  logic          flush = 1'b0;
  logic [4:0]    note;
  logic          gate;
  logic          note_start;
  logic          busy;
  logic [LW-1:0] level;

  note_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GAPT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_note   (cmd_note),
    .cmd_dur    (cmd_dur),
    .pause      (pause),
    .flush      (flush),
    .note       (note),
    .gate       (gate),
    .note_start (note_start),
    .busy       (busy),
    .level      (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase, queued commands and unpaused cycles left in phase.
  int          m_st = M_IDLE;
  logic [12:0] m_q[$];
  int          m_note = 31;
  int          m_left = 0;
  bit          m_start = 1'b0;

  int cyc = 0;
  int gate_cnt, start_cnt, busy_cnt, start_at, acc_at;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_st = M_IDLE;
    m_note = 31;
    m_left = 0;
    m_start = 1'b0;
  endtask

  task automatic model_finish_phase(input bit acc);
    if (m_q.size() > 0 || acc) m_st = M_LOAD;
    else begin
      m_st = M_IDLE;
      m_note = 31;
    end
  endtask

  task automatic model_update(input bit acc);
    logic [12:0] c;
    if (!rst_n) begin
      model_reset();
    end else if (flush) begin
      model_reset();
    end else begin
      m_start = 1'b0;
      case (m_st)
        M_IDLE: if (m_q.size() > 0 || acc) m_st = M_LOAD;
        M_LOAD: begin
          c = m_q.pop_front();
          if (c[7:0] != 0) begin
            m_st = M_PLAY;
            m_note = int'(c[12:8]);
            m_left = int'(c[7:0]) * TD;
            m_start = 1'b1;
          end else begin
            m_st = M_IDLE;
            m_note = 31;
          end
        end
        M_PLAY: if (!pause) begin
          m_left--;
          if (m_left == 0) begin
            if (GAPT > 0) begin
              m_st = M_GAP;
              m_left = GAPT * TD;
            end else model_finish_phase(acc);
          end
        end
        default: if (!pause) begin
          m_left--;
          if (m_left == 0) model_finish_phase(acc);
        end
      endcase
      if (acc) m_q.push_back({cmd_note, cmd_dur});
    end
  endtask

  // One clock cycle: check outputs against the model, then advance both.
  task automatic step();
    bit exp_ready;
    #1;
    exp_ready = (m_q.size() < DEPTH) && !flush;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_st != M_IDLE));
    chk("level", 32'(level), 32'(m_q.size()));
    chk("note", 32'(note), 32'(m_note));
    chk("gate", 32'(gate), 32'(m_st == M_PLAY && m_note <= 23 && !pause));
    chk("note_start", 32'(note_start), 32'(m_start));
    if (gate === 1'b1) gate_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (note_start === 1'b1) begin
      start_cnt++;
      start_at = cyc;
    end
    last_acc = cmd_valid && exp_ready && rst_n;
    if (last_acc) begin
      acc_at = cyc;
      $display("push cycle=%0d note=%0d dur=%0d level=%0d", cyc, cmd_note, cmd_dur, m_q.size());
    end
    @(posedge clk);
    model_update(last_acc);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_cmd(input int n, input int d);
    cmd_valid = 1'b1;
    cmd_note = 5'(n);
    cmd_dur = 8'(d);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic clr_cnt();
    gate_cnt = 0;
    start_cnt = 0;
    busy_cnt = 0;
    start_at = -1;
  endtask

  int t0, acc8, acc9;

  initial begin
    clr_cnt();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_note", 32'(note), 31);
    chk("rst_gate", 32'(gate), 0);
    chk("rst_start", 32'(note_start), 0);
    chk("rst_ready", 32'(cmd_ready), 1);

    // Single note {9,3} into an idle sequencer.
    clr_cnt();
    t0 = cyc;
    push_cmd(9, 3);
    run(20);
    chk("s1_start_latency", 32'(start_at - t0), 2);
    chk("s1_gate_cycles", 32'(gate_cnt), 12);
    chk("s1_busy_cycles", 32'(busy_cnt), 17);
    chk("s1_note_idle", 32'(note), 31);

    // Fill the FIFO while a note plays; the 9th command waits for a LOAD pop.
    push_cmd(5, 2);
    acc8 = -1;
    acc9 = -1;
    for (int k = 0; k < 9; k++) begin
      cmd_valid = 1'b1;
      cmd_note = 5'(k);
      cmd_dur = 8'd1;
      for (int w = 0; w < 40; w++) begin
        step();
        if (last_acc) break;
      end
      chk("s2_accepted", 32'(last_acc), 1);
      if (k == 7) acc8 = acc_at;
      if (k == 8) acc9 = acc_at;
    end
    cmd_valid = 1'b0;
    #1;
    chk("s2_level_full", 32'(level), 8);
    chk("s2_ready_full", 32'(cmd_ready), 0);
    chk("s2_9th_delay", 32'(acc9 - acc8), 7);
    run(120);
    chk("s2_drained", 32'(busy), 0);

    // Rest, zero-length skip, then the highest valid note.
    clr_cnt();
    push_cmd(31, 2);
    push_cmd(0, 0);
    push_cmd(23, 1);
    run(40);
    chk("s3_starts", 32'(start_cnt), 2);
    chk("s3_gate_cycles", 32'(gate_cnt), 4);
    chk("s3_busy_cycles", 32'(busy_cnt), 23);

    // Pause for five cycles in the middle of {12,2}.
    clr_cnt();
    push_cmd(12, 2);
    run(3);
    pause = 1'b1;
    run(5);
    pause = 1'b0;
    run(25);
    chk("s4_gate_cycles", 32'(gate_cnt), 8);
    chk("s4_busy_cycles", 32'(busy_cnt), 18);

    // Flush with a simultaneous push while three commands are queued.
    push_cmd(1, 4);
    push_cmd(2, 1);
    push_cmd(3, 1);
    push_cmd(4, 1);
    #1;
    chk("s5_pre_level", 32'(level), 3);
    clr_cnt();
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_note = 5'd5;
    cmd_dur = 8'd1;
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("s5_busy", 32'(busy), 0);
    chk("s5_level", 32'(level), 0);
    chk("s5_note", 32'(note), 31);
    run(15);
    chk("s5_no_starts", 32'(start_cnt), 0);

    // Reset pulse during the gap of the first of three notes.
    push_cmd(7, 1);
    push_cmd(8, 1);
    push_cmd(9, 1);
    run(4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clr_cnt();
    #1;
    chk("s6_busy", 32'(busy), 0);
    chk("s6_level", 32'(level), 0);
    chk("s6_note", 32'(note), 31);
    chk("s6_gate", 32'(gate), 0);
    chk("s6_ready", 32'(cmd_ready), 1);
    run(15);
    chk("s6_no_starts", 32'(start_cnt), 0);

    // Randomized traffic with occasional pause, flush and reset.
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 99) < 30);
      cmd_note = 5'($urandom_range(0, 31));
      cmd_dur = 8'($urandom_range(0, 3));
      pause = ($urandom_range(0, 99) < 8);
      flush = ($urandom_range(0, 249) == 0);
      rst_n = !($urandom_range(0, 399) == 0);
      step();
    end
    cmd_valid = 1'b0;
    pause = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    run(200);
    chk("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
